// File: rtl/smi_mem_fuzz_test_sequencer.sv
// Sweep sequencer for the burst-64 memory fuzz tester: takes one sweep command,
// walks consecutive address regions issuing one tester config per region,
// folds each region status into running totals and returns one summary result.
module smi_mem_fuzz_test_sequencer #(
  parameter int RegionCountWidth = 16,
  parameter bit StopOnError      = 1'b0
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        cmdValid,
  input  logic [63:0]                 cmdAddrBase,
  input  logic [31:0]                 cmdRegionSize,
  input  logic [RegionCountWidth-1:0] cmdNumRegions,
  input  logic [31:0]                 cmdTestsPerRegion,
  output logic                        cmdStop,
  output logic                        cfgValid,
  output logic [63:0]                 cfgMemAddrBase,
  output logic [31:0]                 cfgMemBlockSize,
  output logic [31:0]                 cfgNumTests,
  input  logic                        cfgStop,
  input  logic                        statValid,
  input  logic [31:0]                 statErrorCount,
  input  logic [63:0]                 statDataCount,
  output logic                        statStop,
  output logic                        resultValid,
  output logic [31:0]                 resultErrorCount,
  output logic [63:0]                 resultDataCount,
  output logic [RegionCountWidth-1:0] resultFailRegions,
  output logic [RegionCountWidth-1:0] resultFirstFail,
  input  logic                        resultStop
);

  localparam int RCW = RegionCountWidth;

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_ISSUE_CFG,
    S_WAIT_STAT,
    S_REPORT
  } state_t;

  state_t         state_q, state_d;
  logic [63:0]    addr_q, addr_d;     // address of the region currently being configured
  logic [31:0]    size_q, size_d;
  logic [31:0]    tests_q, tests_d;
  logic [RCW-1:0] num_q, num_d;
  logic [RCW-1:0] idx_q, idx_d;
  logic [31:0]    err_q, err_d;
  logic [63:0]    data_q, data_d;
  logic [RCW-1:0] fail_q, fail_d;
  logic [RCW-1:0] first_q, first_d;

  logic [RCW-1:0] idx_inc;
  logic           stat_fail;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [RCW-1:0] sat_inc(input logic [RCW-1:0] a);
    logic [RCW-1:0] one;
    one = {{(RCW-1){1'b0}}, 1'b1};
    return (&a) ? a : a + one;
  endfunction

  assign idx_inc   = idx_q + {{(RCW-1){1'b0}}, 1'b1};
  assign stat_fail = (statErrorCount != 32'd0);

  // Next-state, register updates and handshake outputs for the sweep FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    tests_d     = tests_q;
    num_d       = num_q;
    idx_d       = idx_q;
    err_d       = err_q;
    data_d      = data_q;
    fail_d      = fail_q;
    first_d     = first_q;
    cmdStop     = 1'b1;
    cfgValid    = 1'b0;
    statStop    = 1'b1;
    resultValid = 1'b0;
    case (state_q)
      S_RESET: state_d = S_IDLE;
      S_IDLE: begin
        cmdStop = 1'b0;
        if (cmdValid) begin
          addr_d  = cmdAddrBase;
          size_d  = cmdRegionSize;
          tests_d = cmdTestsPerRegion;
          num_d   = cmdNumRegions;
          idx_d   = '0;
          err_d   = '0;
          data_d  = '0;
          fail_d  = '0;
          first_d = '1;
          state_d = (cmdNumRegions == '0) ? S_REPORT : S_ISSUE_CFG;
        end
      end
      S_ISSUE_CFG: begin
        cfgValid = 1'b1;
        if (!cfgStop) state_d = S_WAIT_STAT;
      end
      S_WAIT_STAT: begin
        statStop = 1'b0;
        if (statValid) begin
          err_d  = sat_add32(err_q, statErrorCount);
          data_d = data_q + statDataCount;
          if (stat_fail) begin
            fail_d = sat_inc(fail_q);
            if (&first_q) first_d = idx_q;
          end
          idx_d  = idx_inc;
          // Next region address is built by accumulation; overflow wraps silently.
          addr_d = addr_q + {32'd0, size_q};
          if ((idx_inc == num_q) || (StopOnError && stat_fail)) state_d = S_REPORT;
          else                                                  state_d = S_ISSUE_CFG;
        end
      end
      S_REPORT: begin
        resultValid = 1'b1;
        if (!resultStop) state_d = S_IDLE;
      end
      default: state_d = S_RESET;
    endcase
  end

  // Control state register; only the FSM state sees reset.
  always_ff @(posedge clk) begin
    if (srst) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  // Sweep parameters and accumulators; always reloaded on command accept.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    size_q  <= size_d;
    tests_q <= tests_d;
    num_q   <= num_d;
    idx_q   <= idx_d;
    err_q   <= err_d;
    data_q  <= data_d;
    fail_q  <= fail_d;
    first_q <= first_d;
  end

  assign cfgMemAddrBase    = addr_q;
  assign cfgMemBlockSize   = size_q;
  assign cfgNumTests       = tests_q;
  assign resultErrorCount  = err_q;
  assign resultDataCount   = data_q;
  assign resultFailRegions = fail_q;
  assign resultFirstFail   = first_q;

endmodule
